// File: rtl/boot_load_pkg.sv
// Shared types and port-select encoding for the boot loader and the accumulator core.
package boot_load_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    typedef logic [1:0] req_idx_t;

    localparam logic [3:0] PORT_SEL_A = 4'd0;
    localparam logic [3:0] PORT_SEL_B = 4'd2;
    localparam logic [3:0] PORT_SEL_C = 4'd4;
    localparam logic [3:0] PORT_SEL_D = 4'd6;

    function automatic logic [3:0] port_sel_of(input req_idx_t idx);
        case (idx)
            2'd0:    return PORT_SEL_A;
            2'd1:    return PORT_SEL_B;
            2'd2:    return PORT_SEL_C;
            default: return PORT_SEL_D;
        endcase
    endfunction

    function automatic req_idx_t onehot_to_idx(input logic [3:0] onehot);
        req_idx_t idx;
        idx = '0;
        for (int i = 0; i < 4; i++) begin
            if (onehot[i]) idx = req_idx_t'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Round-robin first-set-bit finder: lowest requester at or after pointer, wrapping.
module rr_pick4
    import boot_load_pkg::*;
(
    input  logic [3:0] req,
    input  req_idx_t   pointer,
    output logic [3:0] pick,
    output logic       valid
);

    req_idx_t idx;

    // Scan from the farthest candidate down so the nearest one to pointer wins.
    always_comb begin
        pick = '0;
        idx  = '0;
        for (int k = 3; k >= 0; k--) begin
            idx = pointer + req_idx_t'(k);
            if (req[idx]) pick = 4'b0001 << idx;
        end
    end

    assign valid = |req;

endmodule

// File: rtl/boot_load_arbiter.sv
// Loader/run controller: round-robin burst arbitration of four loaders onto the core
// write port, and bounded execution of the core on start.
module boot_load_arbiter
    import boot_load_pkg::*;
#(
    parameter int ADDR_WIDTH    = 6,
    parameter int DATA_WIDTH    = 11,
    parameter int RUN_CNT_WIDTH = 16,
    parameter int TIMEOUT       = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [3:0]               req,
    input  logic [3:0]               req_last,
    input  logic [4*ADDR_WIDTH-1:0]  req_addr,
    input  logic [4*DATA_WIDTH-1:0]  req_data,
    output logic [3:0]               ack,
    output logic [3:0]               grant,
    input  logic                     start,
    input  logic [RUN_CNT_WIDTH-1:0] run_budget,
    input  logic                     halt,
    output logic                     cpu_reset,
    output logic                     cpu_wr,
    output logic [ADDR_WIDTH-1:0]    cpu_address,
    output logic [DATA_WIDTH-1:0]    cpu_data,
    output logic [3:0]               cpu_port_sel,
    output logic [1:0]               state,
    output logic                     err_timeout
);

    localparam int GAP_W = $clog2(TIMEOUT + 1);

    state_t                   cur_state;
    req_idx_t                 pointer;
    req_idx_t                 owner;
    logic [3:0]               pick;
    logic                     pick_valid;
    logic [GAP_W-1:0]         gap_cnt;
    logic [RUN_CNT_WIDTH-1:0] run_cnt;
    logic [ADDR_WIDTH-1:0]    addr_arr [4];
    logic [DATA_WIDTH-1:0]    data_arr [4];
    logic                     word_ack;
    logic                     last_ack;
    logic                     gap_expired;
    logic                     run_done;

    rr_pick4 u_pick (
        .req     (req),
        .pointer (pointer),
        .pick    (pick),
        .valid   (pick_valid)
    );

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            addr_arr[i] = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            data_arr[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign owner       = onehot_to_idx(grant);
    assign ack         = (cur_state == LOAD) ? (grant & req) : 4'b0000;
    assign word_ack    = |ack;
    assign last_ack    = |(ack & req_last);
    assign gap_expired = (gap_cnt + GAP_W'(1)) == GAP_W'(TIMEOUT);
    // A zero counter means an unbounded run, so only halt can end it.
    assign run_done    = halt || (run_cnt == RUN_CNT_WIDTH'(1));
    assign state       = cur_state;

    // cpu_reset is set alongside every cpu_wr/state update so it always equals
    // NOT(cpu_wr OR RUN) without a combinational path to the core.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_state    <= IDLE;
            grant        <= '0;
            pointer      <= '0;
            gap_cnt      <= '0;
            run_cnt      <= '0;
            err_timeout  <= 1'b0;
            cpu_reset    <= 1'b1;
            cpu_wr       <= 1'b0;
            cpu_address  <= '0;
            cpu_data     <= '0;
            cpu_port_sel <= '0;
        end else begin
            case (cur_state)
                IDLE: begin
                    cpu_wr  <= 1'b0;
                    gap_cnt <= '0;
                    if (pick_valid) begin
                        grant     <= pick;
                        cur_state <= LOAD;
                        cpu_reset <= 1'b1;
                    end else if (start) begin
                        run_cnt     <= run_budget;
                        err_timeout <= 1'b0;
                        cur_state   <= RUN;
                        cpu_reset   <= 1'b0;
                    end else begin
                        cpu_reset <= 1'b1;
                    end
                end
                LOAD: begin
                    cpu_wr    <= word_ack;
                    cpu_reset <= !word_ack;
                    if (word_ack) begin
                        cpu_address  <= addr_arr[owner];
                        cpu_data     <= data_arr[owner];
                        cpu_port_sel <= port_sel_of(owner);
                        gap_cnt      <= '0;
                        if (last_ack) begin
                            grant     <= '0;
                            pointer   <= owner + req_idx_t'(1);
                            cur_state <= IDLE;
                        end
                    end else if (gap_expired) begin
                        grant       <= '0;
                        err_timeout <= 1'b1;
                        pointer     <= owner + req_idx_t'(1);
                        cur_state   <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                RUN: begin
                    cpu_wr <= 1'b0;
                    if (run_cnt != '0) run_cnt <= run_cnt - RUN_CNT_WIDTH'(1);
                    if (run_done) begin
                        cur_state <= IDLE;
                        cpu_reset <= 1'b1;
                    end else begin
                        cpu_reset <= 1'b0;
                    end
                end
                default: begin
                    cur_state <= IDLE;
                    grant     <= '0;
                    cpu_wr    <= 1'b0;
                    cpu_reset <= 1'b1;
                end
            endcase
        end
    end

endmodule
